// File: rtl/gray_pkg.sv
// Shared constants and types for the RGB-to-gray luma pipeline.
// The BT.601 weights must sum to 256 so the >>8 rescale is exact and rounding stays in range.
package gray_pkg;
    localparam int W_R    = 77;
    localparam int W_G    = 150;
    localparam int W_B    = 29;
    localparam int ROUND  = 128;
    localparam int PIX_W  = 8;
    localparam int PROD_W = 16;

    localparam bit WEIGHTS_OK = ((W_R + W_G + W_B) == 256);

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;
endpackage

// File: rtl/frame_pixel_counter.sv
// Counts emitted pixels within a frame and flags the final pixel index.
module frame_pixel_counter #(
    parameter int PIXELS_PER_FRAME = 1024,
    parameter int CNT_W            = $clog2(PIXELS_PER_FRAME)
) (
    input  logic             CLK,
    input  logic             CLEAR,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    assign last = (count == CNT_W'(PIXELS_PER_FRAME - 1));

    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/rgb_to_gray_pipe.sv
// Three-stage BT.601 luma pipeline: weighted products, rounded sum, rescale to 8 bits.
// A downstream Hold freezes every stage; the output strobe is suppressed while held.
module rgb_to_gray_pipe
    import gray_pkg::*;
#(
    parameter int PIXELS_PER_FRAME = 1024,
    parameter int CNT_W            = $clog2(PIXELS_PER_FRAME)
) (
    input  logic             CLK,
    input  logic             CLEAR,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [7:0]       R_In,
    input  logic [7:0]       G_In,
    input  logic [7:0]       B_In,
    input  logic             Hold,
    output logic [7:0]       Gray_Out,
    output logic             Out_Enable,
    output logic             Frame_Done,
    output logic [CNT_W-1:0] Pixel_Count
);
    if (!WEIGHTS_OK) begin : g_weight_check
        $error("gray_pkg weights must sum to 256");
    end

    function automatic logic [PROD_W-1:0] weigh(input logic [PIX_W-1:0] c, input int w);
        return PROD_W'(w) * PROD_W'(c);
    endfunction

    rgb_t              pix;
    logic              v1, v2, v3;
    logic [PROD_W-1:0] p_r, p_g, p_b;
    logic [PROD_W-1:0] sum;
    logic              last;

    assign pix = '{r: R_In, g: G_In, b: B_In};

    // Handshake: a pixel transfers on any rising edge where In_Valid and In_Ready are both 1;
    // In_Ready drops whenever Hold is high or the block is in reset, so nothing is consumed then.
    assign In_Ready   = CLEAR & ~Hold;
    assign Out_Enable = v3 & ~Hold;
    assign Frame_Done = Out_Enable & last;

    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            v1  <= 1'b0;
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
        end else if (!Hold) begin
            v1 <= In_Valid;
            if (In_Valid) begin
                p_r <= weigh(pix.r, W_R);
                p_g <= weigh(pix.g, W_G);
                p_b <= weigh(pix.b, W_B);
            end
        end
    end

    // Worst case 255*256 + 128 = 65408, so the 16-bit sum cannot wrap.
    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            v2  <= 1'b0;
            sum <= '0;
        end else if (!Hold) begin
            v2 <= v1;
            if (v1) begin
                sum <= p_r + p_g + p_b + PROD_W'(ROUND);
            end
        end
    end

    // Gray_Out only moves when a real pixel arrives, so it holds across bubbles.
    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            v3       <= 1'b0;
            Gray_Out <= '0;
        end else if (!Hold) begin
            v3 <= v2;
            if (v2) begin
                Gray_Out <= PIX_W'(sum >> 8);
            end
        end
    end

    frame_pixel_counter #(
        .PIXELS_PER_FRAME(PIXELS_PER_FRAME),
        .CNT_W           (CNT_W)
    ) u_counter (
        .CLK  (CLK),
        .CLEAR(CLEAR),
        .inc  (Out_Enable),
        .count(Pixel_Count),
        .last (last)
    );
endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Bench for rgb_to_gray_pipe: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of pixel ages, frame index and rounded luma arithmetic.
module tb_rgb_to_gray_pipe;
    localparam int PPF = 4;
    localparam int CW  = $clog2(PPF);

    logic          CLK = 1'b0;
    logic          CLEAR = 1'b0;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [7:0]    R_In = '0, G_In = '0, B_In = '0;
    logic          Hold = 1'b0;
    logic [7:0]    Gray_Out;
    logic          Out_Enable;
    logic          Frame_Done;
    logic [CW-1:0] Pixel_Count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // model state
    logic [7:0] exp_q[$];
    int         age_q[$];
    int         acc_q[$];
    int         model_cnt = 0;
    logic [7:0] last_gray = '0;
    logic       exp_oe;

    // emission log for the directed scenarios
    logic [7:0] got_q[$];
    int         lat_q[$];
    int         emc_q[$];
    int         cnt_q[$];
    logic       fd_q[$];

    rgb_to_gray_pipe #(.PIXELS_PER_FRAME(PPF)) dut (
        .CLK        (CLK),
        .CLEAR      (CLEAR),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .R_In       (R_In),
        .G_In       (G_In),
        .B_In       (B_In),
        .Hold       (Hold),
        .Gray_Out   (Gray_Out),
        .Out_Enable (Out_Enable),
        .Frame_Done (Frame_Done),
        .Pixel_Count(Pixel_Count)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] gray_of(input int r, input int g, input int b);
        int s;
        s = 77 * r + 150 * g + 29 * b + 128;
        return 8'(s / 256);
    endfunction

    task automatic drive(input logic v, input logic h, input int r, input int g, input int b);
        @(posedge CLK);
        #1;
        In_Valid = v;
        Hold     = h;
        R_In     = 8'(r);
        G_In     = 8'(g);
        B_In     = 8'(b);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge CLK);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge CLK);
    endtask

    task automatic clear_log();
        got_q.delete();
        lat_q.delete();
        emc_q.delete();
        cnt_q.delete();
        fd_q.delete();
    endtask

    // Compare process: one pass per cycle at the falling edge, then advance the model
    // by what the next rising edge will see.
    always @(negedge CLK) begin
        if (!CLEAR) begin
            check("rst_gray", Gray_Out, 0);
            check("rst_oe", Out_Enable, 0);
            check("rst_fd", Frame_Done, 0);
            check("rst_cnt", Pixel_Count, 0);
            check("rst_ready", In_Ready, 0);
            exp_q.delete();
            age_q.delete();
            acc_q.delete();
            model_cnt = 0;
            last_gray = '0;
        end else begin
            exp_oe = (age_q.size() > 0) && (age_q[0] == 3) && !Hold;
            check("in_ready", In_Ready, !Hold);
            check("out_enable", Out_Enable, exp_oe);
            if (exp_oe) begin
                check("gray", Gray_Out, exp_q[0]);
                check("pixel_count", Pixel_Count, model_cnt);
                check("frame_done", Frame_Done, model_cnt == PPF - 1);
                got_q.push_back(Gray_Out);
                lat_q.push_back(cyc - acc_q[0] + 1);
                emc_q.push_back(cyc);
                cnt_q.push_back(int'(Pixel_Count));
                fd_q.push_back(Frame_Done);
            end else begin
                check("fd_idle", Frame_Done, 0);
                if (age_q.size() > 0 && age_q[0] == 3)
                    check("gray_held", Gray_Out, exp_q[0]);
                else
                    check("gray_kept", Gray_Out, last_gray);
            end
            if (!Hold) begin
                if (exp_oe) begin
                    last_gray = exp_q.pop_front();
                    void'(age_q.pop_front());
                    void'(acc_q.pop_front());
                    model_cnt = (model_cnt + 1) % PPF;
                end
                foreach (age_q[i]) age_q[i] = age_q[i] + 1;
                if (In_Valid) begin
                    exp_q.push_back(gray_of(R_In, G_In, B_In));
                    age_q.push_back(1);
                    acc_q.push_back(cyc + 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 CLEAR = 1'b1;
        idle();

        // primaries back-to-back
        clear_log();
        drive(1, 0, 255, 0, 0);
        drive(1, 0, 0, 255, 0);
        drive(1, 0, 0, 0, 255);
        drain();
        check("prim_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("prim_r", got_q[0], 77);
            check("prim_g", got_q[1], 149);
            check("prim_b", got_q[2], 29);
            check("prim_latency", lat_q[0], 3);
            check("prim_consec1", emc_q[1] - emc_q[0], 1);
            check("prim_consec2", emc_q[2] - emc_q[0], 2);
        end

        // extremes and a mixed value
        clear_log();
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 255, 255, 255);
        drive(1, 0, 100, 150, 200);
        drain();
        check("ext_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("ext_black", got_q[0], 0);
            check("ext_white", got_q[1], 255);
            check("ext_mixed", got_q[2], 141);
        end

        // hold for two cycles after the second accept
        clear_log();
        drive(1, 0, 10, 20, 30);
        drive(1, 0, 200, 100, 50);
        drive(1, 1, 1, 2, 3);
        drive(1, 1, 1, 2, 3);
        drive(1, 0, 1, 2, 3);
        drive(1, 0, 255, 128, 0);
        drain();
        check("hold_n", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("hold_p1", got_q[0], gray_of(10, 20, 30));
            check("hold_p2", got_q[1], gray_of(200, 100, 50));
            check("hold_p3", got_q[2], gray_of(1, 2, 3));
            check("hold_p4", got_q[3], gray_of(255, 128, 0));
            check("hold_lat1", lat_q[0], 5);
            check("hold_lat2", lat_q[1], 5);
            check("hold_lat3", lat_q[2], 3);
        end

        // asynchronous reset with two pixels in flight
        drive(1, 0, 50, 60, 70);
        drive(1, 0, 80, 90, 100);
        idle();
        #2;
        CLEAR = 1'b0;
        #1;
        check("arst_gray", Gray_Out, 0);
        check("arst_oe", Out_Enable, 0);
        check("arst_cnt", Pixel_Count, 0);
        check("arst_ready", In_Ready, 0);
        repeat (2) @(posedge CLK);
        #1 CLEAR = 1'b1;
        clear_log();
        repeat (5) @(posedge CLK);
        check("arst_no_strobe", got_q.size(), 0);

        // frame wrap: nine pixels continuously
        clear_log();
        for (int i = 0; i < 9; i++)
            drive(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        drain();
        check("frame_n", got_q.size(), 9);
        if (got_q.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                check($sformatf("frame_fd%0d", i), fd_q[i], (i == 3 || i == 7) ? 1 : 0);
                check($sformatf("frame_cnt%0d", i), cnt_q[i], i % 4);
            end
        end
        @(negedge CLK);
        check("frame_final_cnt", Pixel_Count, 1);

        // bubbles: valid pattern 1,0,1
        clear_log();
        drive(1, 0, 12, 34, 56);
        drive(0, 0, 200, 200, 200);
        drive(1, 0, 250, 5, 90);
        drain();
        check("bub_n", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("bub_gap", emc_q[1] - emc_q[0], 2);
            check("bub_v0", got_q[0], gray_of(12, 34, 56));
            check("bub_v1", got_q[1], gray_of(250, 5, 90));
        end

        // random traffic with random holds
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
